// File: rtl/if_fetch_unit.sv
// LEGv8 instruction-fetch stage: owns the PC, fetches over an imem req/ack handshake, and feeds ID through a one-entry skid.
// Optional build macro IF_PERF_CNT_EN adds perf_fetch_cnt, a saturating count of ID accepts.
module if_fetch_unit #(
    parameter int unsigned          ADDR_W   = 64,
    parameter int unsigned          INST_W   = 32,
    parameter logic [ADDR_W-1:0]    RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [INST_W-1:0] imem_rdata,
    output logic              inst_valid,
    output logic [INST_W-1:0] inst,
    output logic [ADDR_W-1:0] inst_pc
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0]       perf_fetch_cnt
`endif
);

    // DROP means a request is still in flight but its word must be discarded.
    typedef enum logic [1:0] {
        FS_IDLE = 2'd0,
        FS_WAIT = 2'd1,
        FS_DROP = 2'd2
    } fetch_state_e;

    fetch_state_e      r_state;
    fetch_state_e      w_state_nxt;

    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] r_req_addr;

    logic              r_skid_valid;
    logic [INST_W-1:0] r_skid_inst;
    logic [ADDR_W-1:0] r_skid_pc;

    logic              r_out_valid;
    logic [INST_W-1:0] r_out_inst;
    logic [ADDR_W-1:0] r_out_pc;

    logic              w_issue;
    logic              w_req;
    logic              w_xfer;
    logic              w_take;
    logic              w_out_free;
    logic [ADDR_W-1:0] w_addr;
    logic [ADDR_W-1:0] w_redirect_pc;

    assign w_redirect_pc = {redirect_pc[ADDR_W-1:2], 2'b00};

    // A fresh request starts only when nothing is outstanding, the skid can absorb its word,
    // and no redirect is about to move the PC underneath it.
    assign w_issue    = !rst && (r_state == FS_IDLE) && !r_skid_valid && !redirect;
    assign w_req      = !rst && ((r_state != FS_IDLE) || w_issue);
    assign w_xfer     = w_req && imem_ack;
    assign w_take     = w_xfer && (r_state != FS_DROP) && !redirect;
    assign w_out_free = !r_out_valid || !stall;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        w_addr = '0;
        if (!rst) begin
            if (r_state != FS_IDLE) begin
                w_addr = r_req_addr;
            end else if (w_issue) begin
                w_addr = r_pc;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            FS_IDLE: begin
                if (w_issue && !imem_ack) begin
                    w_state_nxt = FS_WAIT;
                end
            end
            FS_WAIT: begin
                if (imem_ack) begin
                    w_state_nxt = FS_IDLE;
                end else if (redirect) begin
                    w_state_nxt = FS_DROP;
                end
            end
            FS_DROP: begin
                if (imem_ack) begin
                    w_state_nxt = FS_IDLE;
                end
            end
            default: w_state_nxt = FS_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            r_state <= FS_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // The request address is frozen at issue so a redirect cannot disturb a handshake in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_req_addr <= '0;
        end else if (w_issue) begin
            r_req_addr <= r_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc <= RESET_PC;
        end else if (redirect) begin
            r_pc <= w_redirect_pc;
        end else if (w_take) begin
            r_pc <= r_pc + ADDR_W'(4);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: payload registers are reset as well, so inst/inst_pc read zero straight out of reset.
            r_out_valid  <= 1'b0;
            r_out_inst   <= '0;
            r_out_pc     <= '0;
            r_skid_valid <= 1'b0;
            r_skid_inst  <= '0;
            r_skid_pc    <= '0;
        end else if (redirect) begin
            r_out_valid  <= 1'b0;
            r_skid_valid <= 1'b0;
        end else if (w_out_free) begin
            if (r_skid_valid) begin
                r_out_valid  <= 1'b1;
                r_out_inst   <= r_skid_inst;
                r_out_pc     <= r_skid_pc;
                r_skid_valid <= 1'b0;
            end else if (w_take) begin
                r_out_valid <= 1'b1;
                r_out_inst  <= imem_rdata;
                r_out_pc    <= w_addr;
            end else begin
                r_out_valid <= 1'b0;
            end
        end else if (w_take) begin
            r_skid_valid <= 1'b1;
            r_skid_inst  <= imem_rdata;
            r_skid_pc    <= w_addr;
        end
    end

`ifdef IF_PERF_CNT_EN
    logic [31:0] r_perf_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_perf_cnt <= '0;
        end else if (r_out_valid && !stall && (r_perf_cnt != 32'hFFFF_FFFF)) begin
            r_perf_cnt <= r_perf_cnt + 32'd1;
        end
    end

    assign perf_fetch_cnt = r_perf_cnt;
`endif

    assign imem_req   = w_req;
    assign imem_addr  = w_addr;
    assign inst_valid = r_out_valid;
    assign inst       = r_out_inst;
    assign inst_pc    = r_out_pc;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Scoreboard bench for if_fetch_unit: the expected fetch stream is queued from program-flow rules,
// a separate monitor pops and compares on every ID accept; memory latency, stall and redirects are randomised.
module tb_if_fetch_unit;

    localparam int                ADDR_W   = 64;
    localparam int                INST_W   = 32;
    localparam logic [ADDR_W-1:0] RESET_PC = '0;

    logic              clk;
    logic              rst;
    logic              stall;
    logic              redirect;
    logic [ADDR_W-1:0] redirect_pc;
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_ack;
    logic [INST_W-1:0] imem_rdata;
    logic              inst_valid;
    logic [INST_W-1:0] inst;
    logic [ADDR_W-1:0] inst_pc;
`ifdef IF_PERF_CNT_EN
    logic [31:0]       perf_fetch_cnt;
`endif

    typedef struct {
        logic [ADDR_W-1:0] pc;
        logic [INST_W-1:0] word;
    } exp_t;

    exp_t              exp_q[$];
    exp_t              mon_e;
    int                checks     = 0;
    int                errors     = 0;
    int                lat_mode   = 0;
    int                wait_left  = 0;
    int                accept_cnt = 0;
    int                perf_model = 0;
    logic              hold_prev  = 1'b0;
    logic [ADDR_W-1:0] hold_addr  = '0;

    if_fetch_unit #(
        .ADDR_W  (ADDR_W),
        .INST_W  (INST_W),
        .RESET_PC(RESET_PC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .stall      (stall),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .inst_valid (inst_valid),
        .inst       (inst),
        .inst_pc    (inst_pc)
`ifdef IF_PERF_CNT_EN
        ,
        .perf_fetch_cnt(perf_fetch_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Program image: three fixed LEGv8 words at 0/4/8, a hashed word everywhere else.
    function automatic logic [INST_W-1:0] prog_word(input logic [ADDR_W-1:0] a);
        case (a)
            64'h0:   return 32'hF84402C9;
            64'h4:   return 32'h8B09026A;
            64'h8:   return 32'hCB0A028B;
            default: return (a[33:2] * 32'h9E3779B1) ^ a[63:32] ^ 32'h5A5A_0000;
        endcase
    endfunction

    function automatic int pick_lat();
        case (lat_mode)
            0:       return 0;
            1:       return 2;
            default: return int'($urandom_range(0, 3));
        endcase
    endfunction

    // Memory: each request waits wait_left cycles with req high, then acks with the addressed word.
    assign imem_rdata = prog_word(imem_addr);
    assign imem_ack   = imem_req && (wait_left == 0);

    always @(posedge clk) begin
        if (rst || (imem_req && imem_ack)) begin
            wait_left <= pick_lat();
        end else if (imem_req && (wait_left > 0)) begin
            wait_left <= wait_left - 1;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Program flow restarts at start and proceeds word by word; older expectations are flushed.
    task automatic restart_stream(input logic [ADDR_W-1:0] start);
        exp_t e;
        exp_q.delete();
        for (int i = 0; i < 256; i++) begin
            e.pc   = start + ADDR_W'(4 * i);
            e.word = prog_word(e.pc);
            exp_q.push_back(e);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_redirect(input logic [ADDR_W-1:0] pc);
        redirect    = 1'b1;
        redirect_pc = pc;
        restart_stream({pc[ADDR_W-1:2], 2'b00});
    endtask

    // Monitor: every ID accept outside reset/redirect must be the next word of the program flow.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && inst_valid && !stall && !redirect) begin
                check("sb_nonempty", 64'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    mon_e = exp_q.pop_front();
                    check("sb_inst_pc", inst_pc, mon_e.pc);
                    check("sb_inst", 64'(inst), 64'(mon_e.word));
                end
                accept_cnt++;
            end
            if (rst) begin
                perf_model = 0;
            end else if (inst_valid && !stall) begin
                perf_model++;
            end
            if (hold_prev && !rst) begin
                check("imem_addr_hold", imem_addr, hold_addr);
            end
            if (imem_req) begin
                check("imem_addr_align", 64'(imem_addr[1:0]), 0);
            end
            hold_prev = imem_req && !imem_ack && !rst;
            hold_addr = imem_addr;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int                found;
        int                got;
        int                addr_seen;
        int                bubbles;
        int                acc0;
        logic [ADDR_W-1:0] tgt;

        rst         = 1'b1;
        stall       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = '0;
        lat_mode    = 0;
        restart_stream(RESET_PC);

        // Reset held for two clocks, then the first fetch goes out immediately.
        step();
        @(negedge clk);
        check("rst_inst_valid", inst_valid, 0);
        check("rst_imem_req", imem_req, 0);
        step();
        rst = 1'b0;
        @(negedge clk);
        check("boot_imem_req", imem_req, 1);
        check("boot_imem_addr", imem_addr, RESET_PC);

        // Zero-wait stream: one instruction per clock.
        step();
        @(negedge clk);
        check("stream_valid_0", inst_valid, 1);
        check("stream_pc_0", inst_pc, 64'h0);
        step();
        @(negedge clk);
        check("stream_valid_4", inst_valid, 1);
        check("stream_pc_4", inst_pc, 64'h4);

        // Three stalled clocks while pc 8 is presented; pc 12 lands in the skid.
        step();
        stall = 1'b1;
        @(negedge clk);
        check("stall_pc_8", inst_pc, 64'h8);
        check("skid_fill_addr", imem_addr, 64'hC);
        check("skid_fill_ack", imem_ack, 1);
        repeat (2) begin
            step();
            @(negedge clk);
            check("stall_hold_valid", inst_valid, 1);
            check("stall_hold_pc", inst_pc, 64'h8);
            check("stall_skid_full_req", imem_req, 0);
        end
        step();
        stall = 1'b0;
        @(negedge clk);
        check("release_pc_8", inst_pc, 64'h8);
        step();
        @(negedge clk);
        check("release_valid_12", inst_valid, 1);
        check("release_pc_12", inst_pc, 64'hC);
        step();
        @(negedge clk);
        check("release_valid_16", inst_valid, 1);
        check("release_pc_16", inst_pc, 64'h10);

        // Two-wait memory: redirect to 0x40 while the fetch of pc 16 is in flight.
        step();
        lat_mode = 1;
        repeat (4) step();
        do_redirect(64'h10);
        step();
        redirect = 1'b0;
        found = 0;
        for (int i = 0; i < 20 && found == 0; i++) begin
            @(negedge clk);
            if (imem_req && imem_addr == 64'h10 && !imem_ack) found = 1;
            else step();
        end
        check("t4_found_inflight", found, 1);
        step();
        do_redirect(64'h40);
        @(negedge clk);
        check("t4_inflight_at_redirect", 64'(imem_req && !imem_ack && imem_addr == 64'h10), 1);
        step();
        redirect  = 1'b0;
        got       = 0;
        addr_seen = 0;
        bubbles   = 0;
        for (int i = 0; i < 30 && got == 0; i++) begin
            @(negedge clk);
            if (addr_seen == 0 && imem_req && imem_addr != 64'h10) begin
                addr_seen = 1;
                check("t4_next_addr", imem_addr, 64'h40);
            end
            if (inst_valid) begin
                got = 1;
                check("t4_first_pc", inst_pc, 64'h40);
            end else begin
                bubbles++;
                step();
            end
        end
        check("t4_returned", got, 1);
        check("t4_bubbles_ge2", 64'(bubbles >= 2), 1);

        // Redirect and stall together with the skid full.
        step();
        lat_mode = 0;
        stall    = 1'b1;
        found    = 0;
        for (int i = 0; i < 20 && found == 0; i++) begin
            @(negedge clk);
            if (inst_valid && !imem_req) found = 1;
            else step();
        end
        check("t5_skid_full", found, 1);
        step();
        do_redirect(64'h43);
        step();
        redirect = 1'b0;
        @(negedge clk);
        check("t5_inst_valid", inst_valid, 0);
        check("t5_imem_req", imem_req, 1);
        check("t5_imem_addr", imem_addr, 64'h40);
        step();
        stall = 1'b0;
        repeat (6) step();

        // PC wrap-around at the top of the address space.
        do_redirect(64'hFFFF_FFFF_FFFF_FFFA);
        step();
        redirect = 1'b0;
        repeat (10) step();
`ifdef IF_PERF_CNT_EN
        check("perf_running", perf_fetch_cnt, 64'(perf_model));
`endif

        // Reset in the middle of a stall with a request outstanding.
        lat_mode = 1;
        stall    = 1'b1;
        repeat (3) step();
        rst = 1'b1;
        restart_stream(RESET_PC);
        step();
        @(negedge clk);
        check("midrst_inst_valid", inst_valid, 0);
        check("midrst_imem_req", imem_req, 0);
`ifdef IF_PERF_CNT_EN
        check("perf_rst_clear", perf_fetch_cnt, 0);
`endif
        step();
        rst      = 1'b0;
        stall    = 1'b0;
        lat_mode = 0;
        repeat (3) step();
        stall = 1'b1;
        repeat (3) step();
        stall = 1'b0;
        repeat (3) step();
`ifdef IF_PERF_CNT_EN
        check("perf_after_stalls", perf_fetch_cnt, 64'(perf_model));
`endif

        // Randomised traffic: variable latency, stalls, redirects and one reset.
        lat_mode = 2;
        acc0     = accept_cnt;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            step();
            stall = ($urandom_range(0, 9) < 3);
            if (cyc == 1500) begin
                rst = 1'b1;
                restart_stream(RESET_PC);
            end else if (cyc == 1502) begin
                rst = 1'b0;
            end
            if (!rst && $urandom_range(0, 19) == 0) begin
                tgt = ($urandom_range(0, 3) == 0) ? 64'hFFFF_FFFF_FFFF_FF00 : 64'h0;
                tgt = tgt | 64'($urandom_range(0, 255));
                do_redirect(tgt);
            end else begin
                redirect = 1'b0;
            end
        end
        step();
        redirect = 1'b0;
        stall    = 1'b0;
        repeat (10) step();
        check("random_progress", 64'((accept_cnt - acc0) >= 300), 1);
`ifdef IF_PERF_CNT_EN
        check("perf_final", perf_fetch_cnt, 64'(perf_model));
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
